// File: rtl/frame_serializer_if.sv
// Descriptor/serial-output bundle for frame_serializer.
// bus_in packs {valid, payload, len}; the remaining signals are the
// abort request and the registered serializer outputs.
interface frame_serializer_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) ();
  logic [DATA_W+LEN_W:0] bus_in;
  logic                  abort;
  logic                  ready;
  logic                  frame;
  logic                  msg;
  logic                  done;
  logic                  err;

  modport master (
    output bus_in, abort,
    input  ready, frame, msg, done, err
  );

  modport slave (
    input  bus_in, abort,
    output ready, frame, msg, done, err
  );
endinterface

// File: rtl/frame_serializer.sv
// Serializes a captured payload of len bits onto msg while frame is high.
// Flow: IDLE (accept descriptor) -> SHIFT (one setup cycle, then one bit per
// cycle) -> GAP (GAP_CYC forced-low cycles) -> IDLE. Illegal lengths are
// rejected with an err pulse; abort during SHIFT ends the frame early.
module frame_serializer #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 6,
  parameter int MSB_FIRST = 1,
  parameter int GAP_CYC   = 1
) (
  input logic            clk,
  input logic            reset,
  frame_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Gap reload after a normal last bit: the last-bit cycle itself is spent in
  // GAP, so a full GAP_CYC count still follows it. After an abort the err
  // cycle is already the first forced-low cycle, hence one less.
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYC);
  localparam logic [3:0] GAP_ABORT = 4'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_t              state;
  logic [DATA_W-1:0]   payload;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    cnt;
  logic [3:0]          gap_cnt;

  logic                in_valid;
  logic [DATA_W-1:0]   in_payload;
  logic [LEN_W-1:0]    in_len;
  logic                len_ok;
  logic [LEN_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shifted;
  logic                cur_bit;
  logic                last_bit;

  // Descriptor decode and selection of the next payload bit to emit.
  always_comb begin
    in_valid   = bus.bus_in[DATA_W+LEN_W];
    in_payload = bus.bus_in[DATA_W+LEN_W-1:LEN_W];
    in_len     = bus.bus_in[LEN_W-1:0];
    len_ok     = (in_len != {LEN_W{1'b0}}) && (in_len <= LEN_W'(DATA_W));
    if (MSB_FIRST != 0) begin
      bit_idx = len - cnt - LEN_W'(1);
    end else begin
      bit_idx = cnt;
    end
    shifted  = payload >> bit_idx;
    cur_bit  = shifted[0];
    last_bit = (cnt == (len - LEN_W'(1)));
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      payload   <= {DATA_W{1'b0}};
      len       <= {LEN_W{1'b0}};
      cnt       <= {LEN_W{1'b0}};
      gap_cnt   <= 4'd0;
      bus.ready <= 1'b1;
      bus.frame <= 1'b0;
      bus.msg   <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.frame <= 1'b0;
      bus.msg   <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ready && in_valid) begin
            payload   <= in_payload;
            len       <= in_len;
            cnt       <= {LEN_W{1'b0}};
            bus.ready <= 1'b0;
            if (len_ok) begin
              state <= SHIFT;
            end else begin
              // Rejected: stay in IDLE, ready returns on the next edge.
              bus.err <= 1'b1;
            end
          end else begin
            bus.ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            // Abort wins even over the last bit: no done, frame drops now.
            bus.err <= 1'b1;
            if (GAP_CYC == 0) begin
              state     <= IDLE;
              bus.ready <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_ABORT;
            end
          end else begin
            bus.frame <= 1'b1;
            bus.msg   <= cur_bit;
            cnt       <= cnt + LEN_W'(1);
            if (last_bit) begin
              bus.done <= 1'b1;
              if (GAP_CYC == 0) begin
                // ready is still low; IDLE raises it on the next edge.
                state <= IDLE;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              state <= SHIFT;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer. Three instances cover
// MSB-first/GAP=1, LSB-first/GAP=0 and MSB-first/GAP=3. Expected output
// traces are computed per cycle from the frame timing rules.
module tb_frame_serializer;
  localparam int DW = 32;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  frame_serializer_if #(.DATA_W(DW), .LEN_W(LW)) ifa ();
  frame_serializer_if #(.DATA_W(DW), .LEN_W(LW)) ifb ();
  frame_serializer_if #(.DATA_W(DW), .LEN_W(LW)) ifc ();

  frame_serializer #(.DATA_W(DW), .LEN_W(LW), .MSB_FIRST(1), .GAP_CYC(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  frame_serializer #(.DATA_W(DW), .LEN_W(LW), .MSB_FIRST(0), .GAP_CYC(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  frame_serializer #(.DATA_W(DW), .LEN_W(LW), .MSB_FIRST(1), .GAP_CYC(3))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  function automatic int msb_of(int sel);
    return (sel == 1) ? 0 : 1;
  endfunction

  function automatic int gap_of(int sel);
    case (sel)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // {ready, frame, msg, done, err}
  function automatic logic [4:0] outs(int sel);
    case (sel)
      0:       return {ifa.ready, ifa.frame, ifa.msg, ifa.done, ifa.err};
      1:       return {ifb.ready, ifb.frame, ifb.msg, ifb.done, ifb.err};
      default: return {ifc.ready, ifc.frame, ifc.msg, ifc.done, ifc.err};
    endcase
  endfunction

  task automatic drive(int sel, logic v, logic [DW-1:0] p, logic [LW-1:0] l, logic ab);
    case (sel)
      0:       begin ifa.bus_in = {v, p, l}; ifa.abort = ab; end
      1:       begin ifb.bus_in = {v, p, l}; ifb.abort = ab; end
      default: begin ifc.bus_in = {v, p, l}; ifc.abort = ab; end
    endcase
  endtask

  task automatic check(string tag, int cyc, logic [4:0] obs, logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d rdy/frm/msg/done/err observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Sends one descriptor to an idle DUT and checks every cycle until ready
  // returns. ab_j: edge (relative to acceptance edge 0) at which abort is
  // sampled, 0 = none. rst_j: edge at which reset is sampled low, 0 = none.
  task automatic run_frame(string tag, int sel, logic [DW-1:0] p, logic [LW-1:0] l,
                           int ab_j, int rst_j);
    int li, g, fall, last_shift, rdy_c, idx;
    bit legal, aborted, r, f, m, d, e, ab;
    li         = int'(l);
    g          = gap_of(sel);
    legal      = (li >= 1) && (li <= DW);
    aborted    = legal && (ab_j >= 1) && (ab_j <= li);
    fall       = aborted ? ab_j : li + 1;
    last_shift = !legal ? 0 : (aborted ? ab_j : li);
    rdy_c      = legal ? fall + g : 1;
    check({tag, "_pre"}, -1, outs(sel), 5'b10000);
    // Abort at the acceptance edge lands in IDLE and must be ignored.
    drive(sel, 1'b1, p, l, 1'($urandom_range(0, 1)));
    for (int c = 0; c <= rdy_c; c++) begin
      @(negedge clk);
      if (rst_j > 0 && c >= rst_j) begin
        check({tag, "_rst"}, c, outs(sel), 5'b10000);
        reset = 1'b1;
        drive(sel, 1'b0, '0, '0, 1'b0);
        break;
      end
      if (!legal) begin
        check(tag, c, outs(sel), {c >= 1, 1'b0, 1'b0, 1'b0, c == 0});
      end else begin
        r = (c >= rdy_c);
        f = (c >= 1) && (c < fall);
        m = 1'b0;
        if (f) begin
          idx = (msb_of(sel) != 0) ? (li - 1 - (c - 1)) : (c - 1);
          m   = p[idx];
        end
        d = !aborted && (c == li);
        e = aborted && (c == ab_j);
        check(tag, c, outs(sel), {r, f, m, d, e});
      end
      if (c == rdy_c) begin
        drive(sel, 1'b0, '0, '0, 1'b0);
      end else begin
        reset = (rst_j == c + 1) ? 1'b0 : 1'b1;
        ab    = (c + 1 == ab_j) || ((c + 1 > last_shift) && ($urandom_range(0, 1) == 1));
        // Junk descriptors while busy must never be captured.
        drive(sel, 1'b1, DW'($urandom), LW'($urandom), ab);
      end
    end
  endtask

  // Watchdog: the directed sequence is bounded, this only guards a hang.
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pay [0:12];
    logic [LW-1:0] rl;
    int ph, a, rsel, rab;

    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(2, 1'b0, '0, '0, 1'b0);

    // Reset state.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_a", 0, outs(0), 5'b10000);
    check("reset_b", 0, outs(1), 5'b10000);
    check("reset_c", 0, outs(2), 5'b10000);
    reset = 1'b1;
    @(negedge clk);

    // Basic MSB-first frame: 1,0,1,1 then one gap cycle.
    run_frame("msb_b", 0, 32'h0000000B, 6'd4, 0, 0);
    // LSB-first: 0,1,1 with no gap.
    run_frame("lsb_6", 1, 32'h00000006, 6'd3, 0, 0);
    // Rejected lengths and full-width frame.
    run_frame("len0", 0, 32'hDEADBEEF, 6'd0, 0, 0);
    run_frame("len33", 0, 32'hDEADBEEF, 6'd33, 0, 0);
    run_frame("full32", 0, 32'hFFFFFFFF, 6'd32, 0, 0);
    run_frame("full32_c", 2, 32'hA5C3_0F96, 6'd32, 0, 0);
    run_frame("len63_b", 1, 32'h12345678, 6'd63, 0, 0);
    // Abort while bit 2 is on the line, abort on the last-bit edge.
    run_frame("abort_b2", 0, 32'h000000C5, 6'd8, 4, 0);
    run_frame("abort_last", 0, 32'h0000001F, 6'd5, 5, 0);
    run_frame("abort_last_b", 1, 32'h0000001F, 6'd5, 5, 0);
    run_frame("abort_c", 2, 32'h0000F00F, 6'd16, 7, 0);
    run_frame("abort_setup", 2, 32'h00000003, 6'd2, 1, 0);

    // Valid held high with len=2 on the GAP_CYC=0 instance: period of 4.
    for (int k = 0; k < 13; k++) pay[k] = $urandom;
    check("b2b_pre", -1, outs(1), 5'b10000);
    drive(1, 1'b1, pay[0], 6'd2, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ph = c % 4;
      a  = c - ph;
      check("b2b", c, outs(1),
            {ph == 3, (ph == 1) || (ph == 2),
             (ph == 1) ? pay[a][0] : ((ph == 2) ? pay[a][1] : 1'b0),
             ph == 2, 1'b0});
      if (c < 11) drive(1, 1'b1, pay[c + 1], 6'd2, 1'b0);
      else        drive(1, 1'b0, '0, '0, 1'b0);
    end

    // Reset while bit 3 of a len=10 frame is on the line, then a fresh frame.
    run_frame("rst_mid", 0, 32'h000002D6, 6'd10, 0, 5);
    run_frame("after_rst", 0, 32'h00000359, 6'd10, 0, 0);

    // Randomized descriptors across all instances.
    for (int n = 0; n < 40; n++) begin
      rsel = $urandom_range(0, 2);
      rl   = LW'($urandom_range(0, 40));
      rab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(rl) + 2) : 0;
      run_frame("rand", rsel, DW'($urandom), rl, rab, 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
